// File: rtl/rf_wport_arbiter.sv
// Single owner of the register-file write port: sweeps r1..r(REG_NUM-1) to zero after
// reset, then shares the port between writeback and a buffered long-latency unit.
module rf_wport_arbiter #(
   parameter int DATA_W       = 32,
   parameter int ADDR_W       = 5,
   parameter int REG_NUM      = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wb_we,
   input  logic [ADDR_W-1:0] wb_waddr,
   input  logic [DATA_W-1:0] wb_wdata,
   input  logic              mc_valid,
   input  logic [ADDR_W-1:0] mc_waddr,
   input  logic [DATA_W-1:0] mc_wdata,
   output logic              mc_ready,
   output logic              rf_we,
   output logic [ADDR_W-1:0] rf_waddr,
   output logic [DATA_W-1:0] rf_wdata,
   output logic              init_busy,
   output logic              stall_req
);

   localparam logic [0:0]        S_INIT    = 1'b0;
   localparam logic [0:0]        S_RUN     = 1'b1;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(REG_NUM - 1);
   localparam logic [3:0]        LIMIT     = 4'(STARVE_LIMIT);

   logic [0:0]        r_state;
   logic [ADDR_W-1:0] r_cnt;
   logic              r_buf_v;
   logic [ADDR_W-1:0] r_buf_addr;
   logic [DATA_W-1:0] r_buf_data;
   logic [3:0]        r_starve;

   logic w_run;
   logic w_wb_act;
   logic w_drain;
   logic w_kill;
   logic w_accept;
   logic w_blocked;

   // Reset masks every decision so outputs are clean even before state is known.
   assign w_run     = !rst && (r_state == S_RUN);
   assign w_wb_act  = w_run && wb_we && (wb_waddr != '0);
   assign w_drain   = w_run && r_buf_v && !w_wb_act;
   assign w_kill    = w_run && r_buf_v && w_wb_act && (wb_waddr == r_buf_addr);
   assign w_blocked = w_run && r_buf_v && !w_drain && !w_kill;
   assign w_accept  = mc_valid && mc_ready;

   assign mc_ready  = w_run && (!r_buf_v || w_drain);
   assign init_busy = rst || (r_state == S_INIT);
   // A draining entry is no longer starved, so the stall drops in that same cycle.
   assign stall_req = rst || (r_state == S_INIT) ||
                      (r_buf_v && !w_drain && (r_starve >= LIMIT));

   always_comb begin
      rf_we    = 1'b0;
      rf_waddr = '0;
      rf_wdata = '0;
      if (!rst) begin
         if (r_state == S_INIT) begin
            rf_we    = 1'b1;
            rf_waddr = r_cnt;
         end else if (w_wb_act) begin
            rf_we    = 1'b1;
            rf_waddr = wb_waddr;
            rf_wdata = wb_wdata;
         end else if (r_buf_v) begin
            rf_we    = 1'b1;
            rf_waddr = r_buf_addr;
            rf_wdata = r_buf_data;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_INIT;
         r_cnt    <= ADDR_W'(1);
         r_buf_v  <= 1'b0;
         r_starve <= '0;
      end else begin
         if (r_state == S_INIT) begin
            r_cnt <= r_cnt + ADDR_W'(1);
            if (r_cnt == LAST_ADDR)
               r_state <= S_RUN;
         end

         // Results addressed to r0 are accepted and dropped.
         if (w_accept && (mc_waddr != '0)) begin
            r_buf_v    <= 1'b1;
            r_buf_addr <= mc_waddr;
            r_buf_data <= mc_wdata;
         end else if (w_drain || w_kill) begin
            r_buf_v <= 1'b0;
         end

         if (w_blocked)
            r_starve <= (r_starve >= LIMIT) ? r_starve : r_starve + 4'd1;
         else
            r_starve <= '0;
      end
   end

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Directed and random stimulus for rf_wport_arbiter, checked cycle by cycle against a
// queue-based reference model of the write-port rules.
module tb_rf_wport_arbiter;

   localparam int DW    = 32;
   localparam int AW    = 5;
   localparam int NREG  = 32;
   localparam int LIMIT = 4;

   typedef struct packed {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } ent_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          wb_we;
   logic [AW-1:0] wb_waddr;
   logic [DW-1:0] wb_wdata;
   logic          mc_valid;
   logic [AW-1:0] mc_waddr;
   logic [DW-1:0] mc_wdata;
   logic          mc_ready;
   logic          rf_we;
   logic [AW-1:0] rf_waddr;
   logic [DW-1:0] rf_wdata;
   logic          init_busy;
   logic          stall_req;

   int n_cmp  = 0;
   int n_fail = 0;

   // reference model state
   bit   m_init;
   int   m_cnt;
   ent_t m_q[$];
   int   m_starve;

   rf_wport_arbiter #(.DATA_W(DW), .ADDR_W(AW), .REG_NUM(NREG), .STARVE_LIMIT(LIMIT)) dut (
      .clk(clk), .rst(rst),
      .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
      .mc_valid(mc_valid), .mc_waddr(mc_waddr), .mc_wdata(mc_wdata), .mc_ready(mc_ready),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .init_busy(init_busy), .stall_req(stall_req)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Drive one cycle of inputs, check all outputs before the edge, then advance the model.
   task automatic step(input bit r, input bit we, input int wa, input logic [DW-1:0] wd,
                       input bit mv, input int ma, input logic [DW-1:0] md);
      bit            e_we, e_rdy, e_stall, e_busy, wb_act, has, drain, kill;
      logic [AW-1:0] e_a;
      logic [DW-1:0] e_d;
      rst = r; wb_we = we; wb_waddr = AW'(wa); wb_wdata = wd;
      mc_valid = mv; mc_waddr = AW'(ma); mc_wdata = md;
      #1;
      wb_act = we && (wa != 0);
      has    = (m_q.size() != 0);
      drain  = 0; kill = 0;
      e_we = 0; e_a = '0; e_d = '0; e_rdy = 0;
      if (r) begin
         e_stall = 1; e_busy = 1;
      end else if (m_init) begin
         e_we = 1; e_a = AW'(m_cnt); e_stall = 1; e_busy = 1;
      end else begin
         e_busy = 0;
         drain  = has && !wb_act;
         kill   = has && wb_act && (m_q[0].a == AW'(wa));
         if (wb_act) begin
            e_we = 1; e_a = AW'(wa); e_d = wd;
         end else if (has) begin
            e_we = 1; e_a = m_q[0].a; e_d = m_q[0].d;
         end
         e_rdy   = !has || drain;
         e_stall = has && !drain && (m_starve >= LIMIT);
      end
      chk("rf_we", DW'(rf_we), DW'(e_we));
      chk("rf_waddr", DW'(rf_waddr), DW'(e_a));
      chk("rf_wdata", rf_wdata, e_d);
      chk("mc_ready", DW'(mc_ready), DW'(e_rdy));
      chk("stall_req", DW'(stall_req), DW'(e_stall));
      chk("init_busy", DW'(init_busy), DW'(e_busy));
      $display("t=%0t rst=%0d wb=%0d@%0d mc=%0d@%0d -> we=%0d a=%0d d=%h rdy=%0d stall=%0d busy=%0d",
               $time, r, we, wa, mv, ma, rf_we, rf_waddr, rf_wdata, mc_ready, stall_req, init_busy);
      @(posedge clk);
      if (r) begin
         m_init = 1; m_cnt = 1; m_q.delete(); m_starve = 0;
      end else if (m_init) begin
         if (m_cnt == NREG - 1) m_init = 0;
         m_cnt++;
      end else begin
         if (has && !drain && !kill)
            m_starve = (m_starve + 1 > LIMIT) ? LIMIT : m_starve + 1;
         else
            m_starve = 0;
         if (drain || kill) void'(m_q.pop_front());
         if (mv && e_rdy && ma != 0) m_q.push_back('{a: AW'(ma), d: md});
      end
      @(negedge clk);
   endtask

   task automatic idle();
      step(0, 0, 0, '0, 0, 0, '0);
   endtask

   initial begin
      rst = 1; wb_we = 0; wb_waddr = '0; wb_wdata = '0;
      mc_valid = 0; mc_waddr = '0; mc_wdata = '0;
      m_init = 1; m_cnt = 1; m_starve = 0;
      @(negedge clk);

      // reset, then the zero sweep with writeback pulses that must be ignored
      step(1, 0, 0, '0, 0, 0, '0);
      for (int i = 0; i < NREG - 1; i++)
         step(0, (i % 3) == 0, 4, 32'h1234_0000 + i, 0, 0, '0);
      idle();

      // mc result with idle writeback reaches the regfile one cycle later
      step(0, 0, 0, '0, 1, 5, 32'hDEAD_BEEF);
      idle();

      // buffered r7 held behind writeback to r3, then drained
      step(0, 0, 0, '0, 1, 7, 32'h0000_0777);
      step(0, 1, 3, 32'h11, 0, 0, '0);
      idle();

      // starvation: writeback to distinct addresses until the stall, then release
      step(0, 0, 0, '0, 1, 10, 32'hCAFE_0010);
      for (int i = 0; i < 6; i++)
         step(0, 1, 11 + i, 32'h100 + i, 0, 0, '0);
      idle();
      idle();

      // same-address kill: r9 writeback supersedes buffered 0xAA
      step(0, 0, 0, '0, 1, 9, 32'hAA);
      step(0, 1, 9, 32'hBB, 0, 0, '0);
      idle();
      idle();

      // r0 targets: writeback ignored, mc result accepted and dropped
      step(0, 1, 0, 32'h55, 1, 0, 32'h66);
      idle();

      // back-to-back mc stream at one per cycle
      for (int i = 0; i < 4; i++)
         step(0, 0, 0, '0, 1, 20 + i, 32'hB0B0_0000 + i);
      idle();

      // random traffic
      for (int i = 0; i < 400; i++)
         step(0, $urandom_range(0, 99) < 40, $urandom_range(0, NREG - 1), $urandom,
              $urandom_range(0, 99) < 60, $urandom_range(0, NREG - 1), $urandom);

      // reset mid-sweep with mc_valid held high
      step(1, 0, 0, '0, 1, 6, 32'h6666);
      for (int i = 0; i < 10; i++)
         step(0, 0, 0, '0, 1, 6, 32'h6666);
      step(1, 0, 0, '0, 1, 6, 32'h6666);
      for (int i = 0; i < NREG - 1; i++)
         step(0, 0, 0, '0, 1, 6, 32'h6666);
      step(0, 0, 0, '0, 0, 0, '0);
      idle();

      // reset while the buffer is full loses the entry
      step(0, 1, 2, 32'h22, 1, 12, 32'hC12);
      step(1, 1, 2, 32'h22, 0, 0, '0);
      for (int i = 0; i < NREG; i++)
         idle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
